// File: rtl/ecp3_io_pkg.sv
// Shared definitions for the ECP3 I/O gearbox models.
// Bit-order constants are common to the 1:4 input and 4:1 output gearboxes
// so that transmit and receive ordering cannot diverge.
package ecp3_io_pkg;

    localparam int unsigned GEAR_RATIO = 4;
    localparam int unsigned CNT_W      = $clog2(GEAR_RATIO);

    typedef logic [CNT_W-1:0]      gear_cnt_t;
    typedef logic [GEAR_RATIO-1:0] gear_word_t;

    // Position of each parallel bit inside a gear word; also the serial slot.
    localparam int unsigned BIT_DA0 = 0;
    localparam int unsigned BIT_DB0 = 1;
    localparam int unsigned BIT_DA1 = 2;
    localparam int unsigned BIT_DB1 = 3;

    localparam gear_cnt_t CNT_LAST = gear_cnt_t'(GEAR_RATIO - 1);

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_e;

    function automatic gear_word_t pack_word(input logic da0, input logic db0,
                                             input logic da1, input logic db1);
        gear_word_t w;
        w          = '0;
        w[BIT_DA0] = da0;
        w[BIT_DB0] = db0;
        w[BIT_DA1] = da1;
        w[BIT_DB1] = db1;
        return w;
    endfunction

endpackage

// File: rtl/oddrx2_gearbox_tx_if.sv
// Parallel word handshake bus feeding the 4:1 output gearbox.
interface oddrx2_gearbox_tx_if;

    logic da0;
    logic db0;
    logic da1;
    logic db1;
    logic valid;
    logic ready;

    modport master (
        output da0, db0, da1, db1, valid,
        input  ready
    );

    modport slave (
        input  da0, db0, da1, db1, valid,
        output ready
    );

endinterface

// File: rtl/oddrx2_hold_reg.sv
// One-entry holding register (HR/HF) with valid/ready accept logic.
// Usable as a single-entry skid stage: stall_i blocks new accepts,
// clear_i empties the entry when the consumer takes it.
module oddrx2_hold_reg
    import ecp3_io_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      stall_i,
    input  logic                      clear_i,
    oddrx2_gearbox_tx_if.slave        bus,
    output gear_word_t                hr_o,
    output logic                      hf_o
);

    gear_word_t hr_q, hr_d;
    logic       hf_q, hf_d;
    logic       accept;

    assign bus.ready = !hf_q && rst_ni && !stall_i;
    assign accept    = bus.valid && bus.ready;
    assign hr_o      = hr_q;
    assign hf_o      = hf_q;

    // Next-state: take a word on accept, drop the entry when the consumer clears it.
    always_comb begin
        hr_d = hr_q;
        hf_d = hf_q;
        if (clear_i) begin
            hf_d = 1'b0;
        end
        if (accept) begin
            hr_d = pack_word(bus.da0, bus.db0, bus.da1, bus.db1);
            hf_d = 1'b1;
        end
    end

    // Holding register state with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hr_q <= '0;
            hf_q <= 1'b0;
        end else begin
            hr_q <= hr_d;
            hf_q <= hf_d;
        end
    end

endmodule

// File: rtl/oddrx2_gearbox_tx.sv
// 4:1 transmit output gearbox: accepts DA0/DB0/DA1/DB1 words over
// valid/ready and serializes them on Q, DA0 first, one bit per ECLK.
// Optional training pattern insertion is enabled by ODDRX2_TX_TRAIN_EN.
module oddrx2_gearbox_tx
    import ecp3_io_pkg::*;
#(
    parameter logic IDLE_BIT = 1'b0
`ifdef ODDRX2_TX_TRAIN_EN
  , parameter gear_word_t TRAIN_PATTERN = 4'b0101
`endif
) (
    input  logic ECLK,
    input  logic RSTN,
    input  logic DA0,
    input  logic DB0,
    input  logic DA1,
    input  logic DB1,
    input  logic VALID,
    output logic READY,
    output logic Q,
    output logic FRAME,
    output logic ACTIVE,
    output logic UNDERRUN
`ifdef ODDRX2_TX_TRAIN_EN
  , input  logic TRAIN
`endif
);

    oddrx2_gearbox_tx_if u_bus ();

    assign u_bus.da0   = DA0;
    assign u_bus.db0   = DB0;
    assign u_bus.da1   = DA1;
    assign u_bus.db1   = DB1;
    assign u_bus.valid = VALID;
    assign READY       = u_bus.ready;

    gear_word_t hr;
    logic       hf;
    logic       train;
    gear_word_t load_word;

`ifdef ODDRX2_TX_TRAIN_EN
    assign train     = TRAIN;
    assign load_word = train ? TRAIN_PATTERN : hr;
`else
    assign train     = 1'b0;
    assign load_word = hr;
`endif

    tx_state_e  state_q, state_d;
    gear_cnt_t  cnt_q, cnt_d, cnt_inc;
    gear_word_t sr_q, sr_d;
    logic       q_q, q_d;
    logic       frame_q, frame_d;
    logic       active_q, active_d;
    logic       underrun_q, underrun_d;
    logic       load_opp, load_data, load_any;

    // A load slot opens when idle or on the last bit; training takes the slot
    // without consuming the held word.
    assign load_opp  = (state_q == TX_IDLE) || (cnt_q == CNT_LAST);
    assign load_data = load_opp && hf && !train;
    assign load_any  = load_opp && (hf || train);
    assign cnt_inc   = cnt_q + gear_cnt_t'(1);

    oddrx2_hold_reg u_hold (
        .clk_i   (ECLK),
        .rst_ni  (RSTN),
        .stall_i (train),
        .clear_i (load_data),
        .bus     (u_bus),
        .hr_o    (hr),
        .hf_o    (hf)
    );

    // Shifter next-state: load, step to the next bit, or end the stream.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        q_d        = q_q;
        frame_d    = frame_q;
        active_d   = active_q;
        underrun_d = 1'b0;
        if (load_any) begin
            state_d  = TX_SHIFT;
            cnt_d    = '0;
            sr_d     = load_word;
            q_d      = load_word[BIT_DA0];
            frame_d  = 1'b1;
            active_d = 1'b1;
        end else if (state_q == TX_SHIFT && cnt_q != CNT_LAST) begin
            cnt_d   = cnt_inc;
            q_d     = sr_q[cnt_inc];
            frame_d = 1'b0;
        end else if (state_q == TX_SHIFT) begin
            state_d    = TX_IDLE;
            cnt_d      = '0;
            q_d        = IDLE_BIT;
            frame_d    = 1'b0;
            active_d   = 1'b0;
            underrun_d = 1'b1;
        end
    end

    // Shifter and registered output state with asynchronous reset.
    always_ff @(posedge ECLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= TX_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            q_q        <= IDLE_BIT;
            frame_q    <= 1'b0;
            active_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            q_q        <= q_d;
            frame_q    <= frame_d;
            active_q   <= active_d;
            underrun_q <= underrun_d;
        end
    end

    assign Q        = q_q;
    assign FRAME    = frame_q;
    assign ACTIVE   = active_q;
    assign UNDERRUN = underrun_q;

endmodule

// File: tb/tb_oddrx2_gearbox_tx.sv
// Self-checking bench for oddrx2_gearbox_tx (training scenario only when
// ODDRX2_TX_TRAIN_EN is defined).
module tb_oddrx2_gearbox_tx;

    logic ECLK = 1'b0;
    logic RSTN;
    logic q, frame, active, underrun;
`ifdef ODDRX2_TX_TRAIN_EN
    logic train;
`endif

    oddrx2_gearbox_tx_if bus ();

    int errors = 0;
    int checks = 0;

    localparam logic IDLE = 1'b0;

    // Per-cycle expected observation: {Q, FRAME, ACTIVE, UNDERRUN}.
    typedef struct packed {
        logic q;
        logic frame;
        logic active;
        logic underrun;
    } obs_t;

    obs_t       exp_q[$];
    logic [3:0] word_q[$];

    always #5 ECLK = ~ECLK;

    oddrx2_gearbox_tx #(.IDLE_BIT(1'b0)) dut (
        .ECLK     (ECLK),
        .RSTN     (RSTN),
        .DA0      (bus.da0),
        .DB0      (bus.db0),
        .DA1      (bus.da1),
        .DB1      (bus.db1),
        .VALID    (bus.valid),
        .READY    (bus.ready),
        .Q        (q),
        .FRAME    (frame),
        .ACTIVE   (active),
        .UNDERRUN (underrun)
`ifdef ODDRX2_TX_TRAIN_EN
      , .TRAIN    (train)
`endif
    );

    task automatic step();
        @(posedge ECLK);
        #1;
    endtask

    // w[0] = DA0 (sent first) ... w[3] = DB1 (sent last)
    task automatic drive_word(input logic [3:0] w);
        bus.da0 = w[0];
        bus.db0 = w[1];
        bus.da1 = w[2];
        bus.db1 = w[3];
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        bus.valid = 1'b1;
        drive_word(4'hF);
        repeat (3) step();
        checks++;
        if ({q, frame, active, underrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got q/f/a/u=%b want 0000", {q, frame, active, underrun});
        end
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", bus.ready);
        end
        bus.valid = 1'b0;
        RSTN = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: got %b want 1", bus.ready);
        end
    endtask

    task automatic test_single_word();
        obs_t e;
        drive_word(4'b1101);          // DA0..DB1 = 1,0,1,1
        bus.valid = 1'b1;
        exp_q.push_back(obs_t'(4'b1110));
        exp_q.push_back(obs_t'(4'b0010));
        exp_q.push_back(obs_t'(4'b1010));
        exp_q.push_back(obs_t'(4'b1010));
        exp_q.push_back(obs_t'(4'b0001));
        exp_q.push_back(obs_t'(4'b0000));
        step();                       // accept edge
        bus.valid = 1'b0;
        checks++;
        if (bus.ready !== 1'b0 || q !== IDLE) begin
            errors++;
            $display("FAIL single_after_accept: got ready=%b q=%b want ready=0 q=%b", bus.ready, q, IDLE);
        end
        for (int k = 1; exp_q.size() > 0; k++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if ({q, frame, active, underrun} !== e) begin
                errors++;
                $display("FAIL single_word[%0d]: got q/f/a/u=%b want %b", k, {q, frame, active, underrun}, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e;
        logic acc;
        int   acc_k = 0;
        drive_word(4'hA);             // bits 0,1,0,1
        bus.valid = 1'b1;
        step();                       // first word accepted
        drive_word(4'h5);             // bits 1,0,1,0, VALID stays high
        exp_q.push_back(obs_t'(4'b0110));
        exp_q.push_back(obs_t'(4'b1010));
        exp_q.push_back(obs_t'(4'b0010));
        exp_q.push_back(obs_t'(4'b1010));
        exp_q.push_back(obs_t'(4'b1110));
        exp_q.push_back(obs_t'(4'b0010));
        exp_q.push_back(obs_t'(4'b1010));
        exp_q.push_back(obs_t'(4'b0010));
        exp_q.push_back(obs_t'(4'b0001));
        for (int k = 1; exp_q.size() > 0; k++) begin
            acc = bus.valid && bus.ready;
            step();
            if (acc) begin
                bus.valid = 1'b0;
                acc_k = k;
            end
            e = exp_q.pop_front();
            checks++;
            if ({q, frame, active, underrun} !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got q/f/a/u=%b want %b", k, {q, frame, active, underrun}, e);
            end
        end
        bus.valid = 1'b0;
        checks++;
        if (acc_k != 2) begin
            errors++;
            $display("FAIL b2b_accept_cycle: got %0d want 2", acc_k);
        end
    endtask

    task automatic test_loopback();
        int         sent = 0;
        int         rcvd = 0;
        int         bitpos = 0;
        int         cycles = 0;
        logic       acc;
        logic [3:0] cur = '0;
        logic [3:0] rx = '0;
        logic [3:0] e4;
        bus.valid = 1'b0;
        word_q.delete();
        while (rcvd < 64 && cycles < 3000) begin
            if (!bus.valid && sent < 64 && $urandom_range(0, 3) != 0) begin
                cur = 4'($urandom_range(0, 15));
                drive_word(cur);
                bus.valid = 1'b1;
            end
            acc = bus.valid && bus.ready;
            step();
            cycles++;
            if (acc) begin
                word_q.push_back(cur);
                sent++;
                bus.valid = 1'b0;
            end
            if (active) begin
                checks++;
                if (frame !== (bitpos == 0)) begin
                    errors++;
                    $display("FAIL loop_frame: got frame=%b want %b at bit %0d", frame, (bitpos == 0), bitpos);
                end
                rx[bitpos] = q;
                bitpos++;
                if (bitpos == 4) begin
                    bitpos = 0;
                    rcvd++;
                    checks++;
                    if (word_q.size() == 0) begin
                        errors++;
                        $display("FAIL loop_word: got %h want none (nothing sent)", rx);
                    end else begin
                        e4 = word_q.pop_front();
                        if (rx !== e4) begin
                            errors++;
                            $display("FAIL loop_word[%0d]: got %h want %h", rcvd - 1, rx, e4);
                        end
                    end
                end
            end else begin
                checks++;
                if (q !== IDLE || bitpos != 0) begin
                    errors++;
                    $display("FAIL loop_idle: got q=%b bitpos=%0d want q=%b bitpos=0", q, bitpos, IDLE);
                    bitpos = 0;
                end
            end
        end
        checks++;
        if (rcvd != 64) begin
            errors++;
            $display("FAIL loop_count: got %0d want 64 words", rcvd);
        end
        bus.valid = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset_midword();
        drive_word(4'b0011);          // bits 1,1,0,0
        bus.valid = 1'b1;
        step();                       // accept
        drive_word(4'b1001);          // second word, becomes held
        step();                       // load: Q = DA0
        step();                       // Q = DB0, second word accepted
        bus.valid = 1'b0;
        checks++;
        if ({q, frame, active, underrun} !== 4'b1010) begin
            errors++;
            $display("FAIL midword_pre: got q/f/a/u=%b want 1010", {q, frame, active, underrun});
        end
        RSTN = 1'b0;
        #1;
        checks++;
        if ({q, frame, active, underrun} !== 4'b0000 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL midword_reset: got q/f/a/u=%b ready=%b want 0000 ready=0", {q, frame, active, underrun}, bus.ready);
        end
        repeat (2) step();
        RSTN = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if ({q, frame, active, underrun} !== 4'b0000) begin
                errors++;
                $display("FAIL midword_quiet[%0d]: got q/f/a/u=%b want 0000", k, {q, frame, active, underrun});
            end
        end
        drive_word(4'b0101);          // bits 1,0,1,0
        bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
        step();
        checks++;
        if ({q, frame, active, underrun} !== 4'b1110) begin
            errors++;
            $display("FAIL midword_restart: got q/f/a/u=%b want 1110", {q, frame, active, underrun});
        end
        repeat (5) step();
    endtask

`ifdef ODDRX2_TX_TRAIN_EN
    task automatic test_train();
        obs_t e;
        drive_word(4'h3);             // bits 1,1,0,0
        bus.valid = 1'b1;
        step();                       // held word accepted
        bus.valid = 1'b0;
        train = 1'b1;
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(obs_t'(4'b1110));
            exp_q.push_back(obs_t'(4'b0010));
            exp_q.push_back(obs_t'(4'b1010));
            exp_q.push_back(obs_t'(4'b0010));
        end
        exp_q.push_back(obs_t'(4'b1110));
        exp_q.push_back(obs_t'(4'b1010));
        exp_q.push_back(obs_t'(4'b0010));
        exp_q.push_back(obs_t'(4'b0010));
        exp_q.push_back(obs_t'(4'b0001));
        for (int k = 1; exp_q.size() > 0; k++) begin
            if (train) begin
                checks++;
                if (bus.ready !== 1'b0) begin
                    errors++;
                    $display("FAIL train_ready[%0d]: got %b want 0", k, bus.ready);
                end
            end
            step();
            if (k == 12) train = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if ({q, frame, active, underrun} !== e) begin
                errors++;
                $display("FAIL train[%0d]: got q/f/a/u=%b want %b", k, {q, frame, active, underrun}, e);
            end
        end
    endtask
`endif

    initial begin
        bus.valid = 1'b0;
        drive_word(4'h0);
        RSTN = 1'b0;
`ifdef ODDRX2_TX_TRAIN_EN
        train = 1'b0;
`endif
        test_reset();
        test_single_word();
        test_back_to_back();
        test_loopback();
        test_reset_midword();
`ifdef ODDRX2_TX_TRAIN_EN
        test_train();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/oddrx2_gearbox_tx.md
# oddrx2_gearbox_tx

Transmit-side 4:1 output gearbox for the ECP3 I/O simulation library. It accepts 4-bit parallel words (DA0, DB0, DA1, DB1) through a valid/ready handshake and serializes them onto one output bit per clock. Its bit order is the exact inverse of the 1:4 input gearbox, so a loopback through both blocks returns each word unchanged. It sits between fabric logic and the pad model in bench and loopback simulations.

## Interface
- IDLE_BIT, 1'b0: level driven on Q when no word is being shifted.
- TRAIN_PATTERN, 4'b0101: word sent while training; bit 0 goes first. Present only with the Configuration macro.
- ECLK  input  1  sole clock; all state updates on the rising edge.
- RSTN  input  1  asynchronous, active-low reset.
- DA0, DB0, DA1, DB1  input  1 each  parallel word; transmit order is DA0, DB0, DA1, DB1.
- VALID  input  1  word present on DA0..DB1.
- READY  output  1  block can accept a word.
- Q  output  1  serial data, registered.
- FRAME  output  1  high while Q carries DA0 of a word (or bit 0 of a training word).
- ACTIVE  output  1  high while Q carries word or training data.
- UNDERRUN  output  1  one-cycle pulse when a stream ends because no word is ready.
- TRAIN  input  1  requests the training pattern. Present only with the Configuration macro.

## Operation
- Holding register HR (4 bits) with full flag HF. Shift register SR (4 bits), 2-bit bit counter CNT, flag BUSY.
- READY = !HF && RSTN. A word is accepted on an edge where VALID && READY; at that edge the word is copied into HR and HF is set.
- Load condition: (!BUSY || CNT==3) && HF. At a load edge:
  - SR receives HR, CNT becomes 0, BUSY is set, HF is cleared.
  - Q receives DA0, FRAME goes to 1, ACTIVE goes to 1.
- Otherwise, while BUSY and CNT<3:
  - CNT increments.
  - Q takes the next bit: DB0, then DA1, then DB1.
  - FRAME goes to 0.
- At an edge where BUSY && CNT==3 && !HF:
  - BUSY, ACTIVE and FRAME are cleared, and Q becomes IDLE_BIT.
  - UNDERRUN is 1 for exactly that following cycle.
- Accept and load never coincide, because READY is low whenever HF is set. An accept one cycle after a load still gives gapless streaming.
- Reset while RSTN is low:
  - Q=IDLE_BIT, FRAME=0, ACTIVE=0, UNDERRUN=0, READY=0.
  - HF=0, BUSY=0, CNT=0, and SR/HR are cleared to 0.
  - Reset mid-word discards the word in flight and any held word. No UNDERRUN pulse is produced.
- After RSTN deasserts, READY goes to 1 combinationally.

## Timing
- Latency: a word accepted at edge t with the shifter idle gives Q=DA0 after edge t+1 and DB1 after edge t+4.
- Throughput: one word per 4 clocks. READY is high for at least one cycle in every 4 during streaming.
- Sustained stream: a new word accepted at edge t+2 (or later, but no later than t+4) follows DB1 with no idle gap.
- All outputs except READY are registered. READY is combinational from HF and RSTN only.
- VALID/data may change freely when READY=0. Data is held into HR only on the accepting edge.

## Configuration
- Macro: ODDRX2_TX_TRAIN_EN.
- Defined:
  - The TRAIN port and the TRAIN_PATTERN parameter exist.
  - At any load opportunity ((!BUSY || CNT==3)) with TRAIN=1, SR receives TRAIN_PATTERN in place of HR. HF is untouched.
  - READY is forced to 0 while TRAIN=1.
  - FRAME and ACTIVE behave as for data. UNDERRUN is never raised while TRAIN=1.
  - When TRAIN drops, the current pattern word completes, then normal loading resumes.
- Undefined: no TRAIN port and no training logic. The behaviour is identical to the macro defined with TRAIN tied to 0.

## Structure
- Shared package ecp3_io_pkg:
  - localparam GEAR_RATIO=4 and a 2-bit counter type.
  - Bit-order constants shared with the input gearbox, so that transmit and receive ordering cannot diverge.
- One natural sub-module, oddrx2_hold_reg: the HR/HF register with the accept logic, also reusable as a one-entry skid stage.

## Test plan
- Reset: hold RSTN=0 while driving VALID=1 -> Q=IDLE_BIT, READY=0, FRAME=0; after release READY=1.
- Single word: word DA0..DB1=1,0,1,1 accepted at edge t -> Q = 1,0,1,1 after edges t+1..t+4; FRAME only after t+1; UNDERRUN pulse after t+5; Q=IDLE_BIT after that.
- Back-to-back: words 0xA and 0x5 with VALID always high -> 8 consecutive data bits, no idle cycle, FRAME high every 4th cycle, no UNDERRUN.
- Loopback: 64 random words through this block and the 1:4 input gearbox -> received words equal sent words, in order.
- Reset mid-word: RSTN low after the second bit -> Q=IDLE_BIT immediately; no UNDERRUN; the next word after release starts with FRAME=1.
- With ODDRX2_TX_TRAIN_EN: TRAIN=1 for 12 cycles -> Q repeats 1,0,1,0, READY=0; the held word 0x3 is transmitted right after the final pattern word.
